linebuf_window: RTL and testbench
=================================

# linebuf_window

Parametrised sliding-window line buffer for the feature-map datapath. It accepts a raster-order pixel stream under a valid qualifier and exposes a full FSIZE×FSIZE window each time a complete window is available. Image width is set at run time. It feeds the pooling and convolution units in place of the fixed 2×2, width-12 feature buffer.

## Interface
- `DWIDTH`, 16: pixel width in bits, signed two's complement.
- `FSIZE`, 2: window edge length; legal values are 2 or greater.
- `MAXW`, 32: maximum supported image width in pixels.
- `clk` in 1: clock; all state updates on the rising edge.
- `xrst` in 1: reset, asynchronous, active-low.
- `clear` in 1: start-of-frame pulse; synchronous.
- `img_width` in $clog2(MAXW+1): active image width.
- `in_valid` in 1: `read_data` holds a valid pixel this cycle.
- `read_data` in DWIDTH signed: input pixel, raster order.
- `out_valid` out 1: `window` holds a complete, qualified window.
- `window` out FSIZE*FSIZE*DWIDTH: flattened window.

## Operation
- **Storage.** A shift chain of L = (FSIZE-1)*MAXW + FSIZE registers; `sr[0]` is the newest pixel.
- **Shifting.** The chain shifts by one only on a cycle with `in_valid`=1 and `clear`=0. Otherwise it holds.
- **Window taps.**
  - Element (i,j) has i = row, where 0 is the oldest or top row, and j = column, where 0 is the leftmost column.
  - Element (i,j) = `sr[(FSIZE-1-i)*img_width + (FSIZE-1-j)]`.
  - It is packed at `window[(i*FSIZE+j)*DWIDTH +: DWIDTH]`.
  - The taps are driven directly from the registers, with no extra pipeline stage.
- **Column counter `col`.** Counts 0 to `img_width`-1 on each accepted pixel, then wraps to 0.
- **Row tracking.**
  - `row_ph` counts rows modulo FSIZE and advances when `col` wraps.
  - `rows_ok` is a sticky flag set when the accepted pixel lies in row FSIZE-1 or later.
- **Window qualifier.** Evaluated for the pixel just accepted, at position (r,c):
  - Overlap mode requires `rows_ok` and c ≥ FSIZE-1.
  - The window never straddles a line wrap.
- **`clear` behaviour.**
  - Zeroes `col`, `row_ph`, `rows_ok` and `out_valid`.
  - Leaves the data registers untouched; stale data is never qualified.
  - Takes priority over a simultaneous `in_valid`; that pixel is discarded.
- **`img_width` constraints.**
  - Must satisfy FSIZE ≤ `img_width` ≤ MAXW.
  - Must stay stable between `clear` pulses.
  - Other values are a usage error and are not checked.
- **Data gaps.** Gaps in `in_valid` have no effect except delaying output.

## Timing
- **Reset values.** While `xrst`=0: all `sr` entries = 0, so `window` = 0; `out_valid` = 0; counters and `rows_ok` = 0.
- **Latency.** 1 cycle. When a pixel is accepted at edge k, `window` reflects it and `out_valid` is registered high in the cycle after edge k.
- **`out_valid` pulse width.** High for exactly one cycle per qualified pixel. It drops on the next edge unless another qualified pixel is accepted.
- **`window` hold.** Stable while `in_valid`=0; consumers may sample any time `out_valid`=1.
- **Reset mid-frame.** All state returns to reset values immediately; the next pixel is treated as (0,0).
- **Throughput.** One pixel per cycle sustained; no backpressure.

## Configuration
- Macro: `LINEBUF_STRIDE_EN`.
- **Defined:** non-overlapping mode for pooling. Qualification additionally requires `row_ph`==FSIZE-1 and (c+1) mod FSIZE == 0. Only disjoint FSIZE×FSIZE tiles are emitted; partial tiles at the right edge are dropped.
- **Undefined:** overlap mode only, with stride 1. The column-modulo logic is absent.

## Test plan
All scenarios use DWIDTH=16 and in_valid=1 continuously unless stated.
- **Overlap, 4×4 frame.** FSIZE=2, img_width=4, `clear`, stream 1..16 → `out_valid` exactly 9 times, following pixels 6,7,8,10,11,12,14,15,16. The first window (i,j order) is {1,2,5,6}; the last is {11,12,15,16}.
- **Stride mode, 4×4 frame.** `LINEBUF_STRIDE_EN`, same stream → 4 windows after pixels 6,8,14,16: {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16}.
- **FSIZE=3, 5×5 frame.** FSIZE=3, MAXW=8, img_width=5, stream 1..25 → first window after pixel 13 = {1,2,3,6,7,8,11,12,13}; 9 windows in total; signed value -5 at pixel 13 is passed unchanged.
- **Stalls.** Repeat the overlap 4×4 frame with `in_valid` toggling 1,0,0,1,… → identical window sequence; `window` is held during the gaps; each `out_valid` lasts 1 cycle.
- **Clear mid-frame.** Assert `clear` together with pixel 7 → that pixel is dropped; the following stream 1..16 reproduces the overlap result exactly.
- **Reset mid-frame.** Pull `xrst` low during pixel 9 → `out_valid`=0 and `window`=0 immediately; after release, stream 1..16 gives the first window {1,2,5,6}.

Source files
------------

// File: rtl/linebuf_window.sv
// linebuf_window: sliding-window line buffer for the feature-map datapath.
// Accepts a raster-order pixel stream and presents a FSIZE x FSIZE window
// one cycle after each pixel that completes a window. Image width is a
// run-time input. Optional build macro LINEBUF_STRIDE_EN selects
// non-overlapping (stride FSIZE) tiles for pooling; without it the window
// slides with stride 1.
// Handshake: a pixel is accepted on a rising edge where in_valid=1 and
// clear=0; out_valid is a one-cycle pulse with no backpressure, and window
// holds its value until the next accepted pixel.
module linebuf_window #(
  parameter int DWIDTH = 16,
  parameter int FSIZE  = 2,
  parameter int MAXW   = 32
) (
  input  logic                             clk,
  input  logic                             xrst,
  input  logic                             clear,
  input  logic [$clog2(MAXW+1)-1:0]        img_width,
  input  logic                             in_valid,
  input  logic signed [DWIDTH-1:0]         read_data,
  output logic                             out_valid,
  output logic [FSIZE*FSIZE*DWIDTH-1:0]    window
);

  localparam int L  = (FSIZE - 1) * MAXW + FSIZE;
  localparam int CW = $clog2(MAXW + 1);
  localparam int RW = $clog2(FSIZE);
  localparam int IW = $clog2(L);
  localparam logic [RW-1:0] LAST_PH = RW'(FSIZE - 1);

  logic signed [DWIDTH-1:0] sr_q [L];
  logic signed [DWIDTH-1:0] sr_d [L];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_ph_q, row_ph_d;
  logic          rows_ok_q, rows_ok_d;
  logic          out_valid_q, out_valid_d;
`ifdef LINEBUF_STRIDE_EN
  logic [RW-1:0] col_ph_q, col_ph_d;
`endif

  logic accept;
  logic col_last;
  logic rows_ok_now;
  logic qualify;

  // Acceptance and window qualification for the pixel presented this cycle
  always_comb begin
    accept      = in_valid & ~clear;
    col_last    = (col_q == img_width - CW'(1));
    rows_ok_now = rows_ok_q | (row_ph_q == LAST_PH);
    qualify     = rows_ok_now & (col_q >= CW'(FSIZE - 1));
`ifdef LINEBUF_STRIDE_EN
    // Only the bottom-right pixel of a disjoint tile completes a window
    qualify     = qualify & (row_ph_q == LAST_PH) & (col_ph_q == LAST_PH);
`endif
  end

  // Next-state for position counters and the output qualifier
  always_comb begin
    col_d       = col_q;
    row_ph_d    = row_ph_q;
    rows_ok_d   = rows_ok_q;
    out_valid_d = 1'b0;
`ifdef LINEBUF_STRIDE_EN
    col_ph_d    = col_ph_q;
`endif
    if (clear) begin
      col_d     = '0;
      row_ph_d  = '0;
      rows_ok_d = 1'b0;
`ifdef LINEBUF_STRIDE_EN
      col_ph_d  = '0;
`endif
    end else if (accept) begin
      col_d       = col_last ? '0 : col_q + CW'(1);
      if (col_last) begin
        row_ph_d = (row_ph_q == LAST_PH) ? '0 : row_ph_q + RW'(1);
      end
      rows_ok_d   = rows_ok_now;
      out_valid_d = qualify;
`ifdef LINEBUF_STRIDE_EN
      // Column phase restarts at each line so tiles never straddle a wrap
      col_ph_d    = (col_last || col_ph_q == LAST_PH) ? '0 : col_ph_q + RW'(1);
`endif
    end
  end

  // Shift chain: newest pixel enters at index 0; clear does not touch data
  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      sr_d[0] = read_data;
      for (int k = 1; k < L; k++) begin
        sr_d[k] = sr_q[k-1];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int k = 0; k < L; k++) begin
        sr_q[k] <= '0;
      end
      col_q       <= '0;
      row_ph_q    <= '0;
      rows_ok_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef LINEBUF_STRIDE_EN
      col_ph_q    <= '0;
`endif
    end else begin
      for (int k = 0; k < L; k++) begin
        sr_q[k] <= sr_d[k];
      end
      col_q       <= col_d;
      row_ph_q    <= row_ph_d;
      rows_ok_q   <= rows_ok_d;
      out_valid_q <= out_valid_d;
`ifdef LINEBUF_STRIDE_EN
      col_ph_q    <= col_ph_d;
`endif
    end
  end

  // Window taps read straight from the chain; row stride is img_width
  always_comb begin
    logic [IW-1:0] tap_idx;
    window = '0;
    for (int i = 0; i < FSIZE; i++) begin
      for (int j = 0; j < FSIZE; j++) begin
        tap_idx = IW'((FSIZE - 1 - i) * int'(img_width) + (FSIZE - 1 - j));
        window[(i*FSIZE+j)*DWIDTH +: DWIDTH] = sr_q[tap_idx];
      end
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_linebuf_window.sv
// Bench for linebuf_window: a FSIZE=2/MAXW=32 instance and a FSIZE=3/MAXW=8
// instance share clock and reset. A frame-level model (pixel array indexed
// by raster position) predicts qualification and window contents.
module tb_linebuf_window;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic xrst;

  // ---------------- DUT A: FSIZE=2, MAXW=32 ----------------
  logic               a_clear, a_in_valid, a_out_valid;
  logic [5:0]         a_w;
  logic signed [15:0] a_data;
  logic [63:0]        a_window;

  linebuf_window #(.DWIDTH(16), .FSIZE(2), .MAXW(32)) dut_a (
    .clk(clk), .xrst(xrst), .clear(a_clear), .img_width(a_w),
    .in_valid(a_in_valid), .read_data(a_data),
    .out_valid(a_out_valid), .window(a_window)
  );

  // ---------------- DUT B: FSIZE=3, MAXW=8 ----------------
  logic               b_clear, b_in_valid, b_out_valid;
  logic [3:0]         b_w;
  logic signed [15:0] b_data;
  logic [143:0]       b_window;

  linebuf_window #(.DWIDTH(16), .FSIZE(3), .MAXW(8)) dut_b (
    .clk(clk), .xrst(xrst), .clear(b_clear), .img_width(b_w),
    .in_valid(b_in_valid), .read_data(b_data),
    .out_valid(b_out_valid), .window(b_window)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0]  exp_q[$];
  logic [15:0]  px [2][256];
  int           n_pix [2];
  int           fs [2] = '{2, 3};
  int           wd [2];
  logic         hold_ok [2];
  logic [143:0] last_win [2];
  logic         exp_valid, got_valid;
  logic [143:0] exp_win, got_win;

`ifdef LINEBUF_STRIDE_EN
  localparam int N44 = 4;
  localparam int N55 = 1;
`else
  localparam int N44 = 9;
  localparam int N55 = 9;
`endif

  // ---------------- reference model ----------------
  function automatic logic model_qual(input int s, input int k);
    int f = fs[s];
    int r = k / wd[s];
    int c = k % wd[s];
`ifdef LINEBUF_STRIDE_EN
    return (r % f == f - 1) && (c % f == f - 1);
`else
    return (r >= f - 1) && (c >= f - 1);
`endif
  endfunction

  function automatic logic [143:0] model_window(input int s, input int k);
    int f = fs[s];
    int w = wd[s];
    int r = k / w;
    int c = k % w;
    logic [143:0] win = '0;
    for (int i = 0; i < f; i++)
      for (int j = 0; j < f; j++)
        win[(i*f+j)*16 +: 16] = px[s][(r - f + 1 + i) * w + (c - f + 1 + j)];
    return win;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_width(input int s, input int w);
    wd[s] = w;
    if (s == 0) a_w = 6'(w); else b_w = 4'(w);
  endtask

  // Drive one cycle on DUT s, sample #1 after the edge, update the model.
  task automatic feed(input int s, input logic v, input logic [15:0] d, input logic c);
    if (s == 0) begin a_in_valid = v; a_data = d; a_clear = c; end
    else        begin b_in_valid = v; b_data = d; b_clear = c; end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; a_clear = 1'b0;
    b_in_valid = 1'b0; b_clear = 1'b0;
    exp_valid = 1'b0;
    if (c) begin
      n_pix[s]   = 0;
      hold_ok[s] = 1'b0;
    end else if (v) begin
      px[s][n_pix[s]] = d;
      exp_valid = model_qual(s, n_pix[s]);
      if (exp_valid) begin
        exp_win     = model_window(s, n_pix[s]);
        last_win[s] = exp_win;
      end
      hold_ok[s] = exp_valid;
      n_pix[s]++;
    end
    got_valid = (s == 0) ? a_out_valid : b_out_valid;
    got_win   = (s == 0) ? {80'd0, a_window} : b_window;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_clear = 0; a_in_valid = 0; a_data = 0;
    b_clear = 0; b_in_valid = 0; b_data = 0;
    set_width(0, 4); set_width(1, 5);
    xrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_window !== 64'd0) begin errors++; $display("FAIL rst_a_window got=%h exp=0", a_window); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got=%b exp=0", b_out_valid); end
    checks++; if (b_window !== 144'd0) begin errors++; $display("FAIL rst_b_window got=%h exp=0", b_window); end
    xrst = 1'b1;
    n_pix = '{0, 0}; hold_ok = '{1'b0, 1'b0};
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_overlap_4x4();
    int pulses = 0;
    logic [15:0] e;
    set_width(0, 4);
    feed(0, 1'b0, 16'd0, 1'b1);
`ifdef LINEBUF_STRIDE_EN
    exp_q = '{16'd6, 16'd8, 16'd14, 16'd16};
`else
    exp_q = '{16'd6, 16'd7, 16'd8, 16'd10, 16'd11, 16'd12, 16'd14, 16'd15, 16'd16};
`endif
    for (int p = 1; p <= 16; p++) begin
      feed(0, 1'b1, 16'(p), 1'b0);
      checks++;
      if (got_valid !== exp_valid) begin errors++; $display("FAIL ov_valid px=%0d got=%b exp=%b", p, got_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (got_win !== exp_win) begin errors++; $display("FAIL ov_window px=%0d got=%h exp=%h", p, got_win, exp_win); end
      end
      if (got_valid) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ov_extra px=%0d got=pulse exp=none", p); end
        else begin
          e = exp_q.pop_front();
          if (e !== 16'(p)) begin errors++; $display("FAIL ov_pos got=%0d exp=%0d", p, e); end
        end
      end
      if (p == 6) begin
        checks++;
        if (got_win !== {80'd0, 64'h0006_0005_0002_0001}) begin errors++; $display("FAIL ov_first got=%h exp=0006000500020001", got_win); end
      end
      if (p == 16) begin
        checks++;
        if (got_win !== {80'd0, 64'h0010_000F_000C_000B}) begin errors++; $display("FAIL ov_last got=%h exp=0010000f000c000b", got_win); end
      end
    end
    checks++;
    if (pulses !== N44) begin errors++; $display("FAIL ov_count got=%0d exp=%0d", pulses, N44); end
  endtask

  task automatic test_stalls();
    int pulses = 0;
    set_width(0, 4);
    feed(0, 1'b0, 16'd0, 1'b1);
    for (int p = 1; p <= 16; p++) begin
      feed(0, 1'b1, 16'(p), 1'b0);
      checks++;
      if (got_valid !== exp_valid) begin errors++; $display("FAIL st_valid px=%0d got=%b exp=%b", p, got_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (got_win !== exp_win) begin errors++; $display("FAIL st_window px=%0d got=%h exp=%h", p, got_win, exp_win); end
      end
      if (got_valid) pulses++;
      for (int g = 0; g < 2; g++) begin
        feed(0, 1'b0, 16'(16'hDEAD), 1'b0);
        checks++;
        if (got_valid !== 1'b0) begin errors++; $display("FAIL st_pulse px=%0d gap=%0d got=%b exp=0", p, g, got_valid); end
        if (hold_ok[0]) begin
          checks++;
          if (got_win !== last_win[0]) begin errors++; $display("FAIL st_hold px=%0d got=%h exp=%h", p, got_win, last_win[0]); end
        end
      end
    end
    checks++;
    if (pulses !== N44) begin errors++; $display("FAIL st_count got=%0d exp=%0d", pulses, N44); end
  endtask

  task automatic test_clear_mid();
    int pulses = 0;
    set_width(0, 4);
    feed(0, 1'b0, 16'd0, 1'b1);
    for (int p = 1; p <= 6; p++) feed(0, 1'b1, 16'(p), 1'b0);
    feed(0, 1'b1, 16'd7, 1'b1);
    checks++;
    if (got_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", got_valid); end
    for (int p = 1; p <= 16; p++) begin
      feed(0, 1'b1, 16'(p), 1'b0);
      checks++;
      if (got_valid !== exp_valid) begin errors++; $display("FAIL clr_seq_valid px=%0d got=%b exp=%b", p, got_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (got_win !== exp_win) begin errors++; $display("FAIL clr_seq_window px=%0d got=%h exp=%h", p, got_win, exp_win); end
      end
      if (got_valid) pulses++;
    end
    checks++;
    if (pulses !== N44) begin errors++; $display("FAIL clr_count got=%0d exp=%0d", pulses, N44); end
  endtask

  task automatic test_fsize3();
    int pulses = 0;
    logic [15:0] d;
    set_width(1, 5);
    feed(1, 1'b0, 16'd0, 1'b1);
    for (int p = 1; p <= 25; p++) begin
      d = (p == 13) ? 16'hFFFB : 16'(p);
      feed(1, 1'b1, d, 1'b0);
      checks++;
      if (got_valid !== exp_valid) begin errors++; $display("FAIL f3_valid px=%0d got=%b exp=%b", p, got_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (got_win !== exp_win) begin errors++; $display("FAIL f3_window px=%0d got=%h exp=%h", p, got_win, exp_win); end
      end
      if (got_valid) pulses++;
      if (p == 13) begin
        checks++;
        if (got_valid !== 1'b1 || got_win !== 144'hFFFB_000C_000B_0008_0007_0006_0003_0002_0001) begin
          errors++; $display("FAIL f3_first valid=%b got=%h exp=fffb000c000b000800070006000300020001", got_valid, got_win);
        end
      end
    end
    checks++;
    if (pulses !== N55) begin errors++; $display("FAIL f3_count got=%0d exp=%0d", pulses, N55); end
  endtask

  task automatic test_reset_mid();
    set_width(0, 4);
    feed(0, 1'b0, 16'd0, 1'b1);
    for (int p = 1; p <= 8; p++) feed(0, 1'b1, 16'(p), 1'b0);
    a_in_valid = 1'b1; a_data = 16'sd9;
    #2;
    xrst = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_window !== 64'd0) begin errors++; $display("FAIL rm_window got=%h exp=0", a_window); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    xrst = 1'b1;
    n_pix = '{0, 0}; hold_ok = '{1'b0, 1'b0};
    for (int p = 1; p <= 16; p++) begin
      feed(0, 1'b1, 16'(p), 1'b0);
      checks++;
      if (got_valid !== exp_valid) begin errors++; $display("FAIL rm_seq_valid px=%0d got=%b exp=%b", p, got_valid, exp_valid); end
      if (p == 6) begin
        checks++;
        if (got_win !== {80'd0, 64'h0006_0005_0002_0001}) begin errors++; $display("FAIL rm_first got=%h exp=0006000500020001", got_win); end
      end
    end
  endtask

  task automatic test_random();
    int s, w, rows, total;
    for (int fr = 0; fr < 8; fr++) begin
      s    = $urandom_range(0, 1);
      w    = (s == 0) ? $urandom_range(2, 12) : $urandom_range(3, 8);
      rows = $urandom_range(fs[s], 5);
      total = w * rows;
      set_width(s, w);
      feed(s, 1'b0, 16'd0, 1'b1);
      for (int k = 0; k < total; k++) begin
        while ($urandom_range(0, 3) == 0) begin
          feed(s, 1'b0, 16'($urandom), 1'b0);
          checks++;
          if (got_valid !== 1'b0) begin errors++; $display("FAIL rnd_gap_valid fr=%0d got=%b exp=0", fr, got_valid); end
          if (hold_ok[s]) begin
            checks++;
            if (got_win !== last_win[s]) begin errors++; $display("FAIL rnd_hold fr=%0d got=%h exp=%h", fr, got_win, last_win[s]); end
          end
        end
        if ($urandom_range(0, 39) == 0) begin
          feed(s, 1'b1, 16'($urandom), 1'b1);
          checks++;
          if (got_valid !== 1'b0) begin errors++; $display("FAIL rnd_clr_valid fr=%0d got=%b exp=0", fr, got_valid); end
        end
        feed(s, 1'b1, 16'($urandom), 1'b0);
        checks++;
        if (got_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid fr=%0d dut=%0d got=%b exp=%b", fr, s, got_valid, exp_valid); end
        if (exp_valid) begin
          checks++;
          if (got_win !== exp_win) begin errors++; $display("FAIL rnd_window fr=%0d dut=%0d got=%h exp=%h", fr, s, got_win, exp_win); end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_overlap_4x4();
    test_stalls();
    test_clear_mid();
    test_fsize3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
